// File: rtl/ckong_input_cond.sv
// ckong_input_cond: synchronises, debounces and SOCD-cleans joystick bits, and shapes coin
// presses into frame-timed pulses with a gap, queueing up to three pending coins.
module ckong_input_cond #(
    parameter int DEB_CYC      = 12000,
    parameter int COIN_FRAMES  = 3,
    parameter int COIN_GAP     = 2,
    parameter bit SOCD_NEUTRAL = 1'b1
) (
    input  logic        clock_12mhz,
    input  logic        reset,
    input  logic [15:0] joy_raw,
    input  logic        vblank,
    output logic [6:0]  joy_pcfrldu,
    output logic [6:0]  joy_pcfrldu2,
    output logic        coin_busy
);
    localparam int CW = $clog2(DEB_CYC + 1);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
    state_t state, state_next;
    logic [7:0] sync1, sync2, deb, fc, fc_next, fc_inc;
    logic [CW-1:0] cnt [8];
    logic [1:0] q, q_next;
    logic [4:0] dirs;
    logic vblank_d, coin_d, tick, coin_edge, ud_clr, lr_clr, unused_hi;
    assign unused_hi = ^joy_raw[15:8];
    assign tick      = vblank & ~vblank_d;
    assign coin_edge = deb[7] & ~coin_d;
    assign ud_clr    = SOCD_NEUTRAL && deb[3] && deb[2];
    assign lr_clr    = SOCD_NEUTRAL && deb[1] && deb[0];
    assign dirs      = {deb[4], deb[0] & ~lr_clr, deb[1] & ~lr_clr, deb[2] & ~ud_clr, deb[3] & ~ud_clr};
    assign fc_inc    = fc + 8'd1;
    assign coin_busy = state != IDLE || q != 2'd0;
    always_ff @(posedge clock_12mhz)
        for (int i = 0; i < 8; i++)
            if (reset) begin
                cnt[i] <= '0;
                deb[i] <= 1'b0;
            end else if (sync2[i] == deb[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEB_CYC - 1)) begin
                cnt[i] <= '0;
                deb[i] <= sync2[i];
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
    // A coin edge coinciding with a dequeue leaves the queue depth unchanged.
    always_comb begin
        state_next = state;
        fc_next    = fc;
        q_next     = (coin_edge && q != 2'd3) ? q + 2'd1 : q;
        case (state)
            IDLE: if (q != 2'd0) begin
                state_next = PULSE;
                fc_next    = 8'd0;
                q_next     = coin_edge ? q : q - 2'd1;
            end
            PULSE: if (tick) begin
                state_next = (fc_inc == 8'(COIN_FRAMES)) ? GAP : PULSE;
                fc_next    = (fc_inc == 8'(COIN_FRAMES)) ? 8'd0 : fc_inc;
            end
            default: if (tick) begin
                state_next = (fc_inc == 8'(COIN_GAP)) ? IDLE : GAP;
                fc_next    = fc_inc;
            end
        endcase
    end
    always_ff @(posedge clock_12mhz)
        if (reset) begin
            sync1        <= '0;
            sync2        <= '0;
            vblank_d     <= 1'b0;
            coin_d       <= 1'b0;
            state        <= IDLE;
            fc           <= '0;
            q            <= '0;
            joy_pcfrldu  <= '0;
            joy_pcfrldu2 <= '0;
        end else begin
            sync1        <= joy_raw[7:0];
            sync2        <= sync1;
            vblank_d     <= vblank;
            coin_d       <= deb[7];
            state        <= state_next;
            fc           <= fc_next;
            q            <= q_next;
            joy_pcfrldu  <= {state == PULSE, deb[5], dirs};
            joy_pcfrldu2 <= {state == PULSE, deb[6], dirs};
        end
endmodule
